datapath_control_unit: RTL and testbench
========================================

Name: datapath_control_unit

Overview:
- Multi-cycle controller that sequences the DataPath block for a LEGv8 instruction subset.
- Each cycle it drives the full control word (register file, ALU, RAM, PC, IR, bus select) from its FSM state, the instruction word held in the IR, and the ALU status flags.
- Sits beside the DataPath at the CPU top level. It replaces the hand-driven control word used in DataPath bring-up.

Parameters:
- RESET_PC, 64'd0: value loaded into the PC in INIT.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- IR  in  32  instruction word from the DataPath IR output.
- status  in  4  ALU flags {V,C,N,Z}, combinational for the current control word.
- write  out  1  register-file write enable.
- rdAddrA, rdAddrB, wrAddr  out  5 each  register-file addresses.
- K  out  64  constant/immediate.
- FS  out  5  ALU function select.
- C_in  out  1  ALU carry-in.
- B_sel  out  1  1 = K onto ALU B.
- ramWrite  out  1  RAM write enable.
- PC_sel  out  1  1 = K is the PC load source.
- PS  out  2  PC op: 00 hold, 01 +4, 10 load, 11 PC+4+in*4.
- IR_load  out  1  IR capture enable.
- AS  out  1  RAM address select: 1 = PC, 0 = ALU result.
- DS  out  2  bus source: 00 ALU, 01 RAM, 10 PC, 11 K.
- state  out  3  current FSM state, for debug.
- halted  out  1  sticky illegal-opcode flag.
- instr_done  out  1  one-cycle pulse on the last cycle of each instruction.

Behaviour:
- Reset:
  - reset low forces state=INIT and halted=0 asynchronously.
  - While reset is low, every output is 0 (combinationally gated), including PS=00 and IR_load=0.
- INIT, one cycle after reset release: PS=10, PC_sel=1, K=RESET_PC. Next state FETCH.
- FETCH: AS=1, DS=01, IR_load=1, PS=00. Next state EXEC.
- EXEC: decode IR[31:21]. All unlisted outputs are 0.
  - ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000:
    - rdAddrA=IR[9:5], rdAddrB=IR[20:16], wrAddr=IR[4:0].
    - write=1, DS=00, B_sel=0, PS=01.
    - SUB: FS=ADD with B inverted, C_in=1.
    - Go to FETCH.
  - ADDI (IR[31:22]=1001000100): K=zero-extended IR[21:10], B_sel=1, FS=ADD, write=1, wrAddr=IR[4:0], PS=01. Go to FETCH.
  - LDUR 11111000010: address = Rn + sign-extended IR[20:12] (B_sel=1, FS=ADD, AS=0), no write, PS=00. Go to MEM.
  - STUR 11111000000:
    - Same address computation, AS=0.
    - rdAddrB=IR[4:0] supplies store data; ramWrite=1, PS=01.
    - Go to FETCH.
  - B (IR[31:26]=000101): K = sext(IR[25:0]) - 1, PC_sel=0, PS=11, so the PC becomes PC + 4*imm. Go to FETCH.
  - CBZ/CBNZ (IR[31:24]=10110100/10110101):
    - rdAddrA=IR[4:0], B_sel=1, K=0, FS=ADD.
    - Taken when status Z=1 (CBZ) or Z=0 (CBNZ): K = sext(IR[23:5]) - 1 and PS=11. Otherwise PS=01.
    - The K multiplex switches on taken; the Z comparison uses the K=0 pass.
    - Go to FETCH.
  - Any other opcode: halted<=1, PS=00, all enables 0. Go to HALT.
- MEM (LDUR only):
  - Hold the address control of EXEC.
  - DS=01, write=1, wrAddr=IR[4:0], PS=01. Go to FETCH.
- HALT: all enables 0, PS=00. Exits only via reset.
- instr_done:
  - Pulses high in EXEC for single-cycle instructions and in MEM for LDUR.
  - Never asserts in INIT, FETCH or HALT.
- Timing:
  - Latency is 2 cycles per instruction (FETCH, EXEC); LDUR takes 3.
  - The state register is the only flop besides halted. Outputs are combinational from state, IR and status.
- Boundary rules:
  - Branch offset arithmetic is 64-bit two's complement; a PC wrap at 2^64 is allowed and not flagged.
  - wrAddr=31 (XZR) still asserts write; the DataPath ignores it.
  - Reset during MEM or HALT returns to INIT; halted clears.

Decomposition:
- Package ctrl_pkg holds:
  - state encodings INIT=0, FETCH=1, EXEC=2, MEM=3, HALT=4;
  - opcode constants;
  - FS codes: AND=00000, OR=00100, ADD=01000, SUB=01001;
  - PS and DS encodings.
- Sub-module instr_decoder: combinational IR to {op class, Rd/Rn/Rm/Rt, sign-extended immediates}.

Test Plan:
- Reset held low 3 cycles, then released → one INIT cycle with PS=10, K=RESET_PC; next cycle FETCH with IR_load=1, AS=1, DS=01.
- IR=0x8B020020 (ADD X0,X1,X2) in EXEC → rdAddrA=1, rdAddrB=2, wrAddr=0, write=1, FS=01000, PS=01, instr_done=1.
- IR=LDUR X3,[X4,#8] → EXEC: AS=0, K=8, write=0, PS=00; MEM: DS=01, write=1, wrAddr=3, PS=01.
- IR=CBZ X5,#-2 with status Z=1 → PS=11, K=-3; with Z=0 → PS=01, K=0.
- IR=0xFFFFFFFF → halted=1, state=HALT with all enables 0 for 10 cycles; assert reset → halted=0, state=INIT.
- Reset asserted mid-MEM → outputs 0 asynchronously, write never pulses.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Control-unit shared definitions: FSM states, opcodes,
// ALU/PC/bus encodings, decoded-instruction and control-word bundles.
package ctrl_pkg;

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_FETCH = 3'd1,
    ST_EXEC  = 3'd2,
    ST_MEM   = 3'd3,
    ST_HALT  = 3'd4
  } state_t;

  typedef enum logic [3:0] {
    OP_ILL,
    OP_ADD,
    OP_SUB,
    OP_AND,
    OP_ORR,
    OP_ADDI,
    OP_LDUR,
    OP_STUR,
    OP_B,
    OP_CBZ,
    OP_CBNZ
  } op_t;

  localparam logic [10:0] OPC_ADD  = 11'b10001011000;
  localparam logic [10:0] OPC_SUB  = 11'b11001011000;
  localparam logic [10:0] OPC_AND  = 11'b10001010000;
  localparam logic [10:0] OPC_ORR  = 11'b10101010000;
  localparam logic [10:0] OPC_LDUR = 11'b11111000010;
  localparam logic [10:0] OPC_STUR = 11'b11111000000;
  localparam logic [9:0]  OPC_ADDI = 10'b1001000100;
  localparam logic [5:0]  OPC_B    = 6'b000101;
  localparam logic [7:0]  OPC_CBZ  = 8'b10110100;
  localparam logic [7:0]  OPC_CBNZ = 8'b10110101;

  localparam logic [4:0] FS_AND = 5'b00000;
  localparam logic [4:0] FS_OR  = 5'b00100;
  localparam logic [4:0] FS_ADD = 5'b01000;
  localparam logic [4:0] FS_SUB = 5'b01001;

  localparam logic [1:0] PS_HOLD = 2'b00;
  localparam logic [1:0] PS_INC  = 2'b01;
  localparam logic [1:0] PS_LOAD = 2'b10;
  localparam logic [1:0] PS_REL  = 2'b11;

  localparam logic [1:0] DS_ALU = 2'b00;
  localparam logic [1:0] DS_RAM = 2'b01;
  localparam logic [1:0] DS_PC  = 2'b10;
  localparam logic [1:0] DS_K   = 2'b11;

  typedef struct packed {
    op_t         op;
    logic [4:0]  rd;
    logic [4:0]  rn;
    logic [4:0]  rm;
    logic [63:0] imm12_z;
    logic [63:0] imm9_s;
    logic [63:0] imm26_s;
    logic [63:0] imm19_s;
  } dec_t;

  typedef struct packed {
    logic        write;
    logic [4:0]  rd_a;
    logic [4:0]  rd_b;
    logic [4:0]  wr_a;
    logic [63:0] k;
    logic [4:0]  fs;
    logic        c_in;
    logic        b_sel;
    logic        ram_write;
    logic        pc_sel;
    logic [1:0]  ps;
    logic        ir_load;
    logic        a_sel;
    logic [1:0]  ds;
  } ctrl_t;

  // PS=11 adds 4 on top of in*4, so the branch offset is pre-biased by one
  function automatic logic [63:0] br_k(input logic [63:0] imm);
    return imm - 64'd1;
  endfunction

endpackage

// File: rtl/instr_decoder.sv
// Combinational LEGv8 field extraction: opcode class,
// register fields and extended immediates.
module instr_decoder
  import ctrl_pkg::*;
(
  input  logic [31:0] ir,
  output dec_t        dec
);

  always_comb begin
    dec.rd      = ir[4:0];
    dec.rn      = ir[9:5];
    dec.rm      = ir[20:16];
    dec.imm12_z = {52'd0, ir[21:10]};
    dec.imm9_s  = {{55{ir[20]}}, ir[20:12]};
    dec.imm26_s = {{38{ir[25]}}, ir[25:0]};
    dec.imm19_s = {{45{ir[23]}}, ir[23:5]};
    dec.op      = OP_ILL;
    unique case (1'b1)
      (ir[31:21] == OPC_ADD):  dec.op = OP_ADD;
      (ir[31:21] == OPC_SUB):  dec.op = OP_SUB;
      (ir[31:21] == OPC_AND):  dec.op = OP_AND;
      (ir[31:21] == OPC_ORR):  dec.op = OP_ORR;
      (ir[31:21] == OPC_LDUR): dec.op = OP_LDUR;
      (ir[31:21] == OPC_STUR): dec.op = OP_STUR;
      (ir[31:22] == OPC_ADDI): dec.op = OP_ADDI;
      (ir[31:26] == OPC_B):    dec.op = OP_B;
      (ir[31:24] == OPC_CBZ):  dec.op = OP_CBZ;
      (ir[31:24] == OPC_CBNZ): dec.op = OP_CBNZ;
      default:                 dec.op = OP_ILL;
    endcase
  end

endmodule

// File: rtl/datapath_control_unit.sv
// Multi-cycle LEGv8 controller: drives the DataPath control
// word from FSM state, the held IR and the ALU flags.
module datapath_control_unit
  import ctrl_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] IR,
  input  logic [3:0]  status,
  output logic        write,
  output logic [4:0]  rdAddrA,
  output logic [4:0]  rdAddrB,
  output logic [4:0]  wrAddr,
  output logic [63:0] K,
  output logic [4:0]  FS,
  output logic        C_in,
  output logic        B_sel,
  output logic        ramWrite,
  output logic        PC_sel,
  output logic [1:0]  PS,
  output logic        IR_load,
  output logic        AS,
  output logic [1:0]  DS,
  output logic [2:0]  state,
  output logic        halted,
  output logic        instr_done
);

  state_t st, st_nxt;
  logic   halted_q;
  logic   halt_set;
  logic   done;
  logic   taken;
  logic   unused_flags;
  ctrl_t  cw, cw_g;
  dec_t   dec;

  instr_decoder u_dec (
    .ir  (IR),
    .dec (dec)
  );

  assign unused_flags = ^status[3:1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st       <= ST_INIT;
      halted_q <= 1'b0;
    end else begin
      st <= st_nxt;
      if (halt_set) halted_q <= 1'b1;
    end
  end

  assign taken = (dec.op == OP_CBZ) ? status[0] : ~status[0];

  always_comb begin
    cw       = '0;
    st_nxt   = st;
    halt_set = 1'b0;
    done     = 1'b0;
    case (st)
      ST_INIT: begin
        cw.ps     = PS_LOAD;
        cw.pc_sel = 1'b1;
        cw.k      = RESET_PC;
        st_nxt    = ST_FETCH;
      end
      ST_FETCH: begin
        cw.a_sel   = 1'b1;
        cw.ds      = DS_RAM;
        cw.ir_load = 1'b1;
        cw.ps      = PS_HOLD;
        st_nxt     = ST_EXEC;
      end
      ST_EXEC: begin
        done   = 1'b1;
        st_nxt = ST_FETCH;
        unique case (dec.op)
          OP_ADD, OP_SUB, OP_AND, OP_ORR: begin
            cw.rd_a  = dec.rn;
            cw.rd_b  = dec.rm;
            cw.wr_a  = dec.rd;
            cw.write = 1'b1;
            cw.ds    = DS_ALU;
            cw.ps    = PS_INC;
            cw.c_in  = (dec.op == OP_SUB);
            cw.fs    = (dec.op == OP_SUB) ? FS_SUB :
                       (dec.op == OP_AND) ? FS_AND :
                       (dec.op == OP_ORR) ? FS_OR  : FS_ADD;
          end
          OP_ADDI: begin
            cw.rd_a  = dec.rn;
            cw.wr_a  = dec.rd;
            cw.k     = dec.imm12_z;
            cw.b_sel = 1'b1;
            cw.fs    = FS_ADD;
            cw.write = 1'b1;
            cw.ps    = PS_INC;
          end
          OP_LDUR: begin
            cw.rd_a  = dec.rn;
            cw.k     = dec.imm9_s;
            cw.b_sel = 1'b1;
            cw.fs    = FS_ADD;
            cw.ps    = PS_HOLD;
            done     = 1'b0;
            st_nxt   = ST_MEM;
          end
          OP_STUR: begin
            cw.rd_a      = dec.rn;
            cw.rd_b      = dec.rd;
            cw.k         = dec.imm9_s;
            cw.b_sel     = 1'b1;
            cw.fs        = FS_ADD;
            cw.ram_write = 1'b1;
            cw.ps        = PS_INC;
          end
          OP_B: begin
            cw.k  = br_k(dec.imm26_s);
            cw.ps = PS_REL;
          end
          OP_CBZ, OP_CBNZ: begin
            // Z is judged on the K=0 pass-through of Rt
            cw.rd_a  = dec.rd;
            cw.b_sel = 1'b1;
            cw.fs    = FS_ADD;
            cw.k     = taken ? br_k(dec.imm19_s) : 64'd0;
            cw.ps    = taken ? PS_REL : PS_INC;
          end
          default: begin
            done     = 1'b0;
            halt_set = 1'b1;
            st_nxt   = ST_HALT;
          end
        endcase
      end
      ST_MEM: begin
        cw.rd_a  = dec.rn;
        cw.k     = dec.imm9_s;
        cw.b_sel = 1'b1;
        cw.fs    = FS_ADD;
        cw.ds    = DS_RAM;
        cw.write = 1'b1;
        cw.wr_a  = dec.rd;
        cw.ps    = PS_INC;
        done     = 1'b1;
        st_nxt   = ST_FETCH;
      end
      ST_HALT: st_nxt = ST_HALT;
      default: st_nxt = ST_INIT;
    endcase
  end

  assign cw_g       = reset ? cw : '0;
  assign write      = cw_g.write;
  assign rdAddrA    = cw_g.rd_a;
  assign rdAddrB    = cw_g.rd_b;
  assign wrAddr     = cw_g.wr_a;
  assign K          = cw_g.k;
  assign FS         = cw_g.fs;
  assign C_in       = cw_g.c_in;
  assign B_sel      = cw_g.b_sel;
  assign ramWrite   = cw_g.ram_write;
  assign PC_sel     = cw_g.pc_sel;
  assign PS         = cw_g.ps;
  assign IR_load    = cw_g.ir_load;
  assign AS         = cw_g.a_sel;
  assign DS         = cw_g.ds;
  assign state      = reset ? st : ST_INIT;
  assign halted     = reset & halted_q;
  assign instr_done = reset & done;

endmodule

// File: tb/tb_datapath_control_unit.sv
// Bench for datapath_control_unit: vector table fed through
// a scoreboard, plus reset/halt/mid-MEM sequences.
module tb_datapath_control_unit;

  localparam logic [63:0] RPC = 64'h0000_0000_0040_0000;

  logic        clk    = 1'b0;
  logic        reset  = 1'b1;
  logic [31:0] IR     = 32'd0;
  logic [3:0]  status = 4'd0;
  logic        write, C_in, B_sel, ramWrite, PC_sel;
  logic        IR_load, AS, halted, instr_done;
  logic [4:0]  rdAddrA, rdAddrB, wrAddr, FS;
  logic [63:0] K;
  logic [1:0]  PS, DS;
  logic [2:0]  state;

  datapath_control_unit #(.RESET_PC(RPC)) dut (
    .clk        (clk),
    .reset      (reset),
    .IR         (IR),
    .status     (status),
    .write      (write),
    .rdAddrA    (rdAddrA),
    .rdAddrB    (rdAddrB),
    .wrAddr     (wrAddr),
    .K          (K),
    .FS         (FS),
    .C_in       (C_in),
    .B_sel      (B_sel),
    .ramWrite   (ramWrite),
    .PC_sel     (PC_sel),
    .PS         (PS),
    .IR_load    (IR_load),
    .AS         (AS),
    .DS         (DS),
    .state      (state),
    .halted     (halted),
    .instr_done (instr_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  st;
    logic        hl;
    logic        wr;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic [4:0]  wa;
    logic [63:0] k;
    logic [4:0]  fs;
    logic        cin;
    logic        bsel;
    logic        ramw;
    logic        pcsel;
    logic [1:0]  ps;
    logic        irl;
    logic        asel;
    logic [1:0]  ds;
    logic        dn;
  } obs_t;

  typedef struct {
    string       name;
    logic [31:0] ir;
    logic [3:0]  status;
    obs_t        e1;
    bit          two;
    obs_t        e2;
  } vec_t;

  typedef struct {
    obs_t  e;
    string name;
  } sb_t;

  obs_t obs;
  assign obs = {state, halted, write, rdAddrA, rdAddrB, wrAddr, K, FS,
                C_in, B_sel, ramWrite, PC_sel, PS, IR_load, AS, DS,
                instr_done};

  int   checks = 0;
  int   fails  = 0;
  bit   mon_on = 1'b0;
  vec_t vt[$];
  sb_t  exp_q[$];

  function automatic obs_t ex(input logic [2:0] s, input logic [1:0] p,
                              input logic d);
    obs_t r;
    r    = '0;
    r.st = s;
    r.ps = p;
    r.dn = d;
    return r;
  endfunction

  function automatic logic [31:0] enc_r(input logic [10:0] opc,
    input logic [4:0] rm, input logic [4:0] rn, input logic [4:0] rd);
    return {opc, rm, 6'd0, rn, rd};
  endfunction

  function automatic logic [31:0] enc_i(input logic [4:0] rn,
    input logic [4:0] rd, input logic [11:0] imm);
    return {10'b1001000100, imm, rn, rd};
  endfunction

  function automatic logic [31:0] enc_d(input logic [10:0] opc,
    input logic [8:0] imm, input logic [4:0] rn, input logic [4:0] rt);
    return {opc, imm, 2'b00, rn, rt};
  endfunction

  function automatic logic [31:0] enc_b(input logic [25:0] imm);
    return {6'b000101, imm};
  endfunction

  function automatic logic [31:0] enc_cb(input logic [7:0] opc,
    input logic [18:0] imm, input logic [4:0] rt);
    return {opc, imm, rt};
  endfunction

  task automatic addv(input string nm, input logic [31:0] ir,
    input logic [3:0] s, input obs_t e1, input bit two, input obs_t e2);
    vec_t v;
    v.name   = nm;
    v.ir     = ir;
    v.status = s;
    v.e1     = e1;
    v.two    = two;
    v.e2     = e2;
    vt.push_back(v);
  endtask

  task automatic chk(input string nm, input obs_t a, input obs_t e);
    checks++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, a, e);
    end
  endtask

  task automatic wait_state(input logic [2:0] s, input int lim,
                            input string nm);
    int n = 0;
    while (state !== s && n < lim) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (state !== s) begin
      fails++;
      $display("FAIL timeout_%s: state %0d expected %0d", nm, state, s);
    end
  endtask

  always @(negedge clk) begin
    if (mon_on && (state == 3'd2 || state == 3'd3)) begin
      if (exp_q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL sb_underflow: state %0d with no expectation", state);
      end else begin
        sb_t s;
        s = exp_q.pop_front();
        chk(s.name, obs, s.e);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    obs_t e, e2, e_init, e_ldm;
    int   n;

    e = ex(3'd2, 2'b01, 1'b1);
    e.wr = 1; e.ra = 5'd1; e.rb = 5'd2; e.wa = 5'd0; e.fs = 5'b01000;
    addv("add", 32'h8B020020, 4'h0, e, 0, '0);

    e = ex(3'd2, 2'b01, 1'b1);
    e.wr = 1; e.ra = 5'd8; e.rb = 5'd9; e.wa = 5'd7;
    e.fs = 5'b01001; e.cin = 1;
    addv("sub", enc_r(11'b11001011000, 5'd9, 5'd8, 5'd7), 4'h0, e, 0, '0);

    e = ex(3'd2, 2'b01, 1'b1);
    e.wr = 1; e.ra = 5'd11; e.rb = 5'd12; e.wa = 5'd10; e.fs = 5'b00000;
    addv("and", enc_r(11'b10001010000, 5'd12, 5'd11, 5'd10), 4'h0, e, 0, '0);

    e = ex(3'd2, 2'b01, 1'b1);
    e.wr = 1; e.ra = 5'd30; e.rb = 5'd29; e.wa = 5'd31; e.fs = 5'b00100;
    addv("orr_xzr", enc_r(11'b10101010000, 5'd29, 5'd30, 5'd31), 4'h0,
         e, 0, '0);

    e = ex(3'd2, 2'b01, 1'b1);
    e.wr = 1; e.ra = 5'd7; e.wa = 5'd6; e.k = 64'd4095;
    e.bsel = 1; e.fs = 5'b01000;
    addv("addi", enc_i(5'd7, 5'd6, 12'hFFF), 4'h0, e, 0, '0);

    e = ex(3'd2, 2'b00, 1'b0);
    e.ra = 5'd4; e.k = 64'd8; e.bsel = 1; e.fs = 5'b01000;
    e2 = ex(3'd3, 2'b01, 1'b1);
    e2.ra = 5'd4; e2.k = 64'd8; e2.bsel = 1; e2.fs = 5'b01000;
    e2.ds = 2'b01; e2.wr = 1; e2.wa = 5'd3;
    e_ldm = e2;
    addv("ldur", enc_d(11'b11111000010, 9'd8, 5'd4, 5'd3), 4'h0, e, 1, e2);

    e = ex(3'd2, 2'b01, 1'b1);
    e.ra = 5'd6; e.rb = 5'd5; e.k = 64'hFFFF_FFFF_FFFF_FFFF;
    e.bsel = 1; e.fs = 5'b01000; e.ramw = 1;
    addv("stur_neg", enc_d(11'b11111000000, 9'h1FF, 5'd6, 5'd5), 4'h0,
         e, 0, '0);

    e = ex(3'd2, 2'b11, 1'b1);
    e.k = 64'd2;
    addv("b_fwd", enc_b(26'd3), 4'h0, e, 0, '0);

    e = ex(3'd2, 2'b11, 1'b1);
    e.k = 64'hFFFF_FFFF_FDFF_FFFF;
    addv("b_min", enc_b(26'h2000000), 4'h0, e, 0, '0);

    e = ex(3'd2, 2'b11, 1'b1);
    e.k = 64'hFFFF_FFFF_FFFF_FFFF;
    addv("b_zero", enc_b(26'd0), 4'h0, e, 0, '0);

    e = ex(3'd2, 2'b11, 1'b1);
    e.ra = 5'd5; e.bsel = 1; e.fs = 5'b01000;
    e.k = 64'hFFFF_FFFF_FFFF_FFFD;
    addv("cbz_taken", enc_cb(8'b10110100, 19'h7FFFE, 5'd5), 4'b0001,
         e, 0, '0);

    e = ex(3'd2, 2'b01, 1'b1);
    e.ra = 5'd5; e.bsel = 1; e.fs = 5'b01000;
    addv("cbz_not", enc_cb(8'b10110100, 19'h7FFFE, 5'd5), 4'b0000,
         e, 0, '0);

    e = ex(3'd2, 2'b11, 1'b1);
    e.ra = 5'd9; e.bsel = 1; e.fs = 5'b01000; e.k = 64'd3;
    addv("cbnz_taken", enc_cb(8'b10110101, 19'd4, 5'd9), 4'b1110,
         e, 0, '0);

    e = ex(3'd2, 2'b01, 1'b1);
    e.ra = 5'd9; e.bsel = 1; e.fs = 5'b01000;
    addv("cbnz_not", enc_cb(8'b10110101, 19'd4, 5'd9), 4'b0001,
         e, 0, '0);

    e_init = ex(3'd0, 2'b10, 1'b0);
    e_init.pcsel = 1; e_init.k = RPC;

    // reset held low for three cycles, released on a falling edge
    IR = 32'h8B020020;
    #1 reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("reset_zero", obs, '0);
    end
    reset = 1'b1;
    #1 chk("init", obs, e_init);
    @(negedge clk);
    e = ex(3'd1, 2'b00, 1'b0);
    e.irl = 1; e.asel = 1; e.ds = 2'b01;
    chk("fetch", obs, e);

    mon_on = 1'b1;
    foreach (vt[i]) begin
      sb_t s;
      wait_state(3'd1, 20, "fetch_vec");
      IR     = vt[i].ir;
      status = vt[i].status;
      s.e    = vt[i].e1;
      s.name = vt[i].name;
      exp_q.push_back(s);
      if (vt[i].two) begin
        s.e    = vt[i].e2;
        s.name = {vt[i].name, "_mem"};
        exp_q.push_back(s);
      end
      @(negedge clk);
    end
    n = 0;
    while (exp_q.size() != 0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL sb_drain: %0d left expected 0", exp_q.size());
    end
    mon_on = 1'b0;

    // illegal opcode: sticky halt until reset
    wait_state(3'd1, 20, "fetch_ill");
    IR     = 32'hFFFF_FFFF;
    status = 4'd0;
    @(negedge clk);
    chk("ill_exec", obs, ex(3'd2, 2'b00, 1'b0));
    repeat (10) begin
      @(negedge clk);
      e = ex(3'd4, 2'b00, 1'b0);
      e.hl = 1;
      chk("halt_hold", obs, e);
    end
    #2 reset = 1'b0;
    #1 chk("halt_reset", obs, '0);
    @(negedge clk);
    reset = 1'b1;
    #1 chk("init_after_halt", obs, e_init);

    // reset lands in the middle of a LDUR MEM cycle
    IR = enc_d(11'b11111000010, 9'd8, 5'd4, 5'd3);
    wait_state(3'd1, 20, "fetch_mem");
    @(negedge clk);
    @(negedge clk);
    chk("mem_before_reset", obs, e_ldm);
    #2 reset = 1'b0;
    #1 chk("mem_reset", obs, '0);
    repeat (3) begin
      @(negedge clk);
      chk("mem_reset_hold", obs, '0);
    end
    reset = 1'b1;
    #1 chk("init_after_mem", obs, e_init);

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
